// File: rtl/mem_stage_dm.sv
// MEM-stage data memory: combinational extended loads, read-modify-write
// half/byte stores, and a registered commit record for each completed store.
module mem_stage_dm #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [31:0] commit_addr,
    output logic [31:0] commit_data
);

    localparam logic [2:0]  OP_W  = 3'b000;
    localparam logic [2:0]  OP_HU = 3'b001;
    localparam logic [2:0]  OP_HS = 3'b010;
    localparam logic [2:0]  OP_BU = 3'b011;
    localparam logic [2:0]  OP_BS = 3'b100;
    localparam logic [31:0] ADDR_LIMIT = 32'(WORDS * 4);

    logic [31:0]   mem_q [WORDS];
    logic [AW-1:0] idx_c;
    logic [31:0]   cur_c;
    logic [15:0]   half_c;
    logic [7:0]    byte_c;
    logic          is_half_c;
    logic          is_byte_c;
    logic          reserved_c;
    logic          misaligned_c;
    logic          out_of_range_c;
    logic          store_c;
    logic [31:0]   merged_c;

    logic        commit_valid_q, commit_valid_d;
    logic [31:0] commit_pc_q, commit_pc_d;
    logic [31:0] commit_addr_q, commit_addr_d;
    logic [31:0] commit_data_q, commit_data_d;

    // Decode, fault detection and lane extraction from the addressed word.
    always_comb begin
        idx_c          = addr[AW+1:2];
        cur_c          = mem_q[idx_c];
        is_half_c      = (op == OP_HU) || (op == OP_HS);
        is_byte_c      = (op == OP_BU) || (op == OP_BS);
        reserved_c     = (op > OP_BS);
        misaligned_c   = ((op == OP_W) && (addr[1:0] != 2'b00)) || (is_half_c && addr[0]);
        out_of_range_c = (addr >= ADDR_LIMIT);
        fault          = reserved_c || misaligned_c || out_of_range_c;
        store_c        = we && !fault;

        half_c = addr[1] ? cur_c[31:16] : cur_c[15:0];
        case (addr[1:0])
            2'b00:   byte_c = cur_c[7:0];
            2'b01:   byte_c = cur_c[15:8];
            2'b10:   byte_c = cur_c[23:16];
            default: byte_c = cur_c[31:24];
        endcase

        rdata = '0;
        if (!fault) begin
            case (op)
                OP_W:    rdata = cur_c;
                OP_HU:   rdata = {16'h0000, half_c};
                OP_HS:   rdata = {{16{half_c[15]}}, half_c};
                OP_BU:   rdata = {24'h000000, byte_c};
                OP_BS:   rdata = {{24{byte_c[7]}}, byte_c};
                default: rdata = '0;
            endcase
        end
    end

    // Merge store data into the current word; signedness does not matter here.
    always_comb begin
        merged_c = cur_c;
        if (op == OP_W) begin
            merged_c = wdata;
        end else if (is_half_c) begin
            if (addr[1]) merged_c[31:16] = wdata[15:0];
            else         merged_c[15:0]  = wdata[15:0];
        end else if (is_byte_c) begin
            case (addr[1:0])
                2'b00:   merged_c[7:0]   = wdata[7:0];
                2'b01:   merged_c[15:8]  = wdata[7:0];
                2'b10:   merged_c[23:16] = wdata[7:0];
                default: merged_c[31:24] = wdata[7:0];
            endcase
        end
    end

    // Commit record next-state: pulse on a store, otherwise hold the payload.
    always_comb begin
        commit_valid_d = 1'b0;
        commit_pc_d    = commit_pc_q;
        commit_addr_d  = commit_addr_q;
        commit_data_d  = commit_data_q;
        if (store_c) begin
            commit_valid_d = 1'b1;
            commit_pc_d    = pc;
            commit_addr_d  = {addr[31:2], 2'b00};
            commit_data_d  = merged_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                mem_q[AW'(i)] <= '0;
            end
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_addr_q  <= '0;
            commit_data_q  <= '0;
        end else begin
            if (store_c) begin
                mem_q[idx_c] <= merged_c;
            end
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_addr_q  <= commit_addr_d;
            commit_data_q  <= commit_data_d;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
    assign commit_addr  = commit_addr_q;
    assign commit_data  = commit_data_q;

endmodule

// File: tb/tb_mem_stage_dm.sv
// Directed bench for mem_stage_dm: loads, merged stores, faults, async reset.
module tb_mem_stage_dm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] pc = '0;
    logic [31:0] rdata;
    logic        fault;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_addr;
    logic [31:0] commit_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_stage_dm #(.WORDS(1024), .AW(10)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .op(op), .pc(pc),
        .rdata(rdata), .fault(fault), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_addr(commit_addr), .commit_data(commit_data)
    );

    task automatic drive(input logic w, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p);
        we = w; op = o; addr = a; wdata = d; pc = p;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 3'b000, 32'h10, 32'h0, 32'h0);
        #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL reset_cvalid got=%b exp=0", commit_valid); end
        total++; if (commit_data !== 32'h0) begin bad++; $display("FAIL reset_cdata got=%h exp=0", commit_data); end
    endtask

    task automatic test_word_store();
        @(negedge clk);
        drive(1'b1, 3'b000, 32'h10, 32'h12345678, 32'h3000);
        #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rdw_old got=%h exp=%h", rdata, 32'h0); end
        @(posedge clk); #1;
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL word_cvalid got=%b exp=1", commit_valid); end
        total++; if (commit_pc !== 32'h3000) begin bad++; $display("FAIL word_cpc got=%h exp=%h", commit_pc, 32'h3000); end
        total++; if (commit_addr !== 32'h10) begin bad++; $display("FAIL word_caddr got=%h exp=%h", commit_addr, 32'h10); end
        total++; if (commit_data !== 32'h12345678) begin bad++; $display("FAIL word_cdata got=%h exp=%h", commit_data, 32'h12345678); end
        drive(1'b0, 3'b000, 32'h10, 32'h0, 32'h3004);
        #1;
        total++; if (rdata !== 32'h12345678) begin bad++; $display("FAIL word_load got=%h exp=%h", rdata, 32'h12345678); end
        @(posedge clk); #1;
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL word_cvalid_drop got=%b exp=0", commit_valid); end
        total++; if (commit_data !== 32'h12345678) begin bad++; $display("FAIL word_cdata_hold got=%h exp=%h", commit_data, 32'h12345678); end
    endtask

    task automatic test_byte_half();
        @(negedge clk);
        drive(1'b1, 3'b011, 32'h12, 32'hFFFFFF9A, 32'h3008);
        @(posedge clk); #1;
        total++; if (commit_data !== 32'h129A5678) begin bad++; $display("FAIL byte_cdata got=%h exp=%h", commit_data, 32'h129A5678); end
        total++; if (commit_addr !== 32'h10) begin bad++; $display("FAIL byte_caddr got=%h exp=%h", commit_addr, 32'h10); end
        drive(1'b0, 3'b100, 32'h12, 32'h0, 32'h0); #1;
        total++; if (rdata !== 32'hFFFFFF9A) begin bad++; $display("FAIL lb got=%h exp=%h", rdata, 32'hFFFFFF9A); end
        op = 3'b011; #1;
        total++; if (rdata !== 32'h0000009A) begin bad++; $display("FAIL lbu got=%h exp=%h", rdata, 32'h9A); end
        op = 3'b010; #1;
        total++; if (rdata !== 32'h0000129A) begin bad++; $display("FAIL lh got=%h exp=%h", rdata, 32'h129A); end
        op = 3'b001; addr = 32'h10; #1;
        total++; if (rdata !== 32'h00005678) begin bad++; $display("FAIL lhu got=%h exp=%h", rdata, 32'h5678); end
        op = 3'b100; addr = 32'h13; #1;
        total++; if (rdata !== 32'h00000012) begin bad++; $display("FAIL lb_lane3 got=%h exp=%h", rdata, 32'h12); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL byte_odd_fault got=%b exp=0", fault); end
    endtask

    task automatic test_faults();
        @(negedge clk);
        drive(1'b1, 3'b000, 32'h11, 32'hDEADBEEF, 32'h300C); #1;
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL misal_word_fault got=%b exp=1", fault); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL misal_word_rdata got=%h exp=0", rdata); end
        @(posedge clk); #1;
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL misal_no_commit got=%b exp=0", commit_valid); end
        total++; if (commit_data !== 32'h129A5678) begin bad++; $display("FAIL misal_cdata_hold got=%h exp=%h", commit_data, 32'h129A5678); end
        drive(1'b0, 3'b000, 32'h10, 32'h0, 32'h0); #1;
        total++; if (rdata !== 32'h129A5678) begin bad++; $display("FAIL misal_mem_kept got=%h exp=%h", rdata, 32'h129A5678); end
        addr = 32'h1000; #1;
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL range_fault got=%b exp=1", fault); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL range_rdata got=%h exp=0", rdata); end
        addr = 32'hFFC; #1;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL last_word_fault got=%b exp=0", fault); end
        op = 3'b111; addr = 32'h10; #1;
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL op111_fault got=%b exp=1", fault); end
        op = 3'b101; #1;
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL op101_fault got=%b exp=1", fault); end
        op = 3'b010; addr = 32'h13; #1;
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL misal_half_fault got=%b exp=1", fault); end
        // Out-of-range store must not alias onto word 0x10 or commit.
        @(negedge clk);
        drive(1'b1, 3'b000, 32'h1010, 32'hCAFEF00D, 32'h3010);
        @(posedge clk); #1;
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL range_no_commit got=%b exp=0", commit_valid); end
        drive(1'b0, 3'b000, 32'h10, 32'h0, 32'h0); #1;
        total++; if (rdata !== 32'h129A5678) begin bad++; $display("FAIL range_mem_kept got=%h exp=%h", rdata, 32'h129A5678); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h20, 32'h0000AAAA, 32'h3020);
        @(posedge clk); #1;
        total++; if (commit_data !== 32'h0000AAAA) begin bad++; $display("FAIL b2b_first got=%h exp=%h", commit_data, 32'h0000AAAA); end
        drive(1'b1, 3'b010, 32'h22, 32'h1234BBBB, 32'h3024);
        @(posedge clk); #1;
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL b2b_cvalid got=%b exp=1", commit_valid); end
        total++; if (commit_data !== 32'hBBBBAAAA) begin bad++; $display("FAIL b2b_second got=%h exp=%h", commit_data, 32'hBBBBAAAA); end
        total++; if (commit_pc !== 32'h3024) begin bad++; $display("FAIL b2b_cpc got=%h exp=%h", commit_pc, 32'h3024); end
        total++; if (commit_addr !== 32'h20) begin bad++; $display("FAIL b2b_caddr got=%h exp=%h", commit_addr, 32'h20); end
        drive(1'b0, 3'b000, 32'h20, 32'h0, 32'h0); #1;
        total++; if (rdata !== 32'hBBBBAAAA) begin bad++; $display("FAIL b2b_load got=%h exp=%h", rdata, 32'hBBBBAAAA); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1'b1, 3'b000, 32'h30, 32'h55AA55AA, 32'h3030);
        @(posedge clk); #2;
        reset = 1'b1;
        drive(1'b1, 3'b000, 32'h10, 32'h77777777, 32'h3034);
        #1;
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL arst_cvalid got=%b exp=0", commit_valid); end
        total++; if (commit_pc !== 32'h0) begin bad++; $display("FAIL arst_cpc got=%h exp=0", commit_pc); end
        total++; if (commit_addr !== 32'h0) begin bad++; $display("FAIL arst_caddr got=%h exp=0", commit_addr); end
        total++; if (commit_data !== 32'h0) begin bad++; $display("FAIL arst_cdata got=%h exp=0", commit_data); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL arst_rdata got=%h exp=0", rdata); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 3'b000, 32'h10, 32'h0, 32'h0); #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL arst_lost_store got=%h exp=0", rdata); end
        addr = 32'h20; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL arst_mem_clear got=%h exp=0", rdata); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL arst_no_commit got=%b exp=0", commit_valid); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_word_store();
        test_byte_half();
        test_faults();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
